// File: rtl/bist_pattern_ctrl.sv
// BIST wrapper for a combinational CUT: an LFSR supplies stimulus, a MISR compacts
// the responses, and the final signature is compared against a golden value.
module bist_pattern_ctrl #(
    parameter int unsigned    PW    = 8,
    parameter int unsigned    RW    = 8,
    parameter int unsigned    NPAT  = 255,
    parameter logic [PW-1:0]  LPOLY = 8'hB8,
    parameter logic [PW-1:0]  LSEED = 8'h01,
    parameter logic [RW-1:0]  MPOLY = 8'hB8,
    localparam int unsigned   IW    = $clog2(NPAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] golden,
    input  logic [RW-1:0] resp_i,
    output logic [PW-1:0] pat_o,
    output logic          pat_valid,
    output logic [IW-1:0] pat_idx,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] signature,
    output logic          pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NPAT - 1);

    state_t        state;
    logic [PW-1:0] lfsr;
    logic [RW-1:0] misr;
    logic [PW-1:0] lfsr_n;
    logic [RW-1:0] misr_n;

    // Next-step values of the stimulus generator and the response compactor
    assign lfsr_n = {lfsr[PW-2:0], ^(lfsr & LPOLY)};
    assign misr_n = {misr[RW-2:0], ^(misr & MPOLY)} ^ resp_i;

    assign pat_o     = lfsr;
    assign pat_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= LSEED;
            misr      <= '0;
            pat_idx   <= '0;
            signature <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Both resting states accept a new run with the same reload
                    if (start) begin
                        lfsr    <= LSEED;
                        misr    <= '0;
                        pat_idx <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    lfsr    <= lfsr_n;
                    misr    <= misr_n;
                    pat_idx <= pat_idx + IW'(1);
                    if (pat_idx == LAST_IDX) begin
                        signature <= misr_n;
                        pass      <= (misr_n == golden);
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Directed bench for bist_pattern_ctrl with PW=RW=4, taps 4'b1001, seed 1,
// using a 5-pattern instance and a 15-pattern instance.
module tb_bist_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start5, start15;
    logic [3:0] golden5, golden15;
    logic       sel5;
    logic [3:0] resp5, resp15;
    logic [3:0] pat5, pat15;
    logic       pv5, pv15, busy5, busy15, done5, done15, pass5, pass15;
    logic [2:0] idx5;
    logic [3:0] idx15;
    logic [3:0] sig5, sig15;

    int nchk  = 0;
    int nfail = 0;

    logic [3:0] exp5  [5]  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE};
    logic [3:0] exp15 [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                               4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
    logic [15:0] seen;

    always #5 clk = ~clk;

    assign resp5  = sel5 ? pat5 : 4'h0;
    assign resp15 = pat15;

    bist_pattern_ctrl #(.PW(4), .RW(4), .NPAT(5), .LPOLY(4'b1001), .LSEED(4'b0001),
                        .MPOLY(4'b1001)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .golden(golden5), .resp_i(resp5),
        .pat_o(pat5), .pat_valid(pv5), .pat_idx(idx5), .busy(busy5), .done(done5),
        .signature(sig5), .pass(pass5)
    );

    bist_pattern_ctrl #(.PW(4), .RW(4), .NPAT(15), .LPOLY(4'b1001), .LSEED(4'b0001),
                        .MPOLY(4'b1001)) dut15 (
        .clk(clk), .rst(rst), .start(start15), .golden(golden15), .resp_i(resp15),
        .pat_o(pat15), .pat_valid(pv15), .pat_idx(idx15), .busy(busy15), .done(done15),
        .signature(sig15), .pass(pass15)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one 5-pattern run of dut5 starting at its first RUN cycle; ends in DONE
    task automatic run_seq(input string tag);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s pat[%0d]", tag, i), 32'(pat5), 32'(exp5[i]));
            check($sformatf("%s idx[%0d]", tag, i), 32'(idx5), i);
            check($sformatf("%s valid[%0d]", tag, i), 32'(pv5), 1);
            check($sformatf("%s busy[%0d]", tag, i), 32'(busy5), 1);
            check($sformatf("%s done_low[%0d]", tag, i), 32'(done5), 0);
            tick();
        end
        check({tag, " done"}, 32'(done5), 1);
        check({tag, " busy_off"}, 32'(busy5), 0);
        check({tag, " valid_off"}, 32'(pv5), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start5 = 1'b0; start15 = 1'b0;
        golden5 = 4'h0; golden15 = 4'h0; sel5 = 1'b0;
        tick(); tick();

        // Reset state
        check("rst pat_o", 32'(pat5), 32'h1);
        check("rst pat_valid", 32'(pv5), 0);
        check("rst busy", 32'(busy5), 0);
        check("rst done", 32'(done5), 0);
        check("rst pat_idx", 32'(idx5), 0);
        check("rst signature", 32'(sig5), 0);
        check("rst pass", 32'(pass5), 0);

        // Basic run, zero responses, golden 0
        rst = 1'b0;
        start5 = 1'b1; tick(); start5 = 1'b0;
        run_seq("s1");
        check("s2 sig_zero", 32'(sig5), 0);
        check("s2 pass_zero", 32'(pass5), 1);

        // Same stimulus, wrong golden
        golden5 = 4'h1;
        start5 = 1'b1; tick(); start5 = 1'b0;
        check("s2 done_drops", 32'(done5), 0);
        repeat (5) tick();
        check("s2b done", 32'(done5), 1);
        check("s2b sig", 32'(sig5), 0);
        check("s2b pass", 32'(pass5), 0);

        // Golden changed while in DONE: result stays frozen
        golden5 = 4'h0;
        repeat (3) tick();
        check("s6 done_hold", 32'(done5), 1);
        check("s6 pass_frozen", 32'(pass5), 0);
        check("s6 sig_frozen", 32'(sig5), 0);
        check("s6 idx_hold", 32'(idx5), 5);
        check("s6 lfsr_hold", 32'(pat5), 32'hD);

        // Buffer CUT on the 5-pattern instance: MISR trace 1,0,7,0,E
        sel5 = 1'b1; golden5 = 4'hE;
        start5 = 1'b1; tick(); start5 = 1'b0;
        repeat (5) tick();
        check("buf5 done", 32'(done5), 1);
        check("buf5 sig", 32'(sig5), 32'hE);
        check("buf5 pass", 32'(pass5), 1);

        // Reset during the third RUN cycle aborts the run
        sel5 = 1'b0; golden5 = 4'h0;
        start5 = 1'b1; tick(); start5 = 1'b0;
        tick(); tick();
        check("s4 third_pat", 32'(pat5), 32'h7);
        rst = 1'b1; tick(); rst = 1'b0;
        check("s4 pat_o", 32'(pat5), 32'h1);
        check("s4 busy", 32'(busy5), 0);
        check("s4 done", 32'(done5), 0);
        check("s4 idx", 32'(idx5), 0);
        tick();
        check("s4 idle_hold", 32'(busy5), 0);
        start5 = 1'b1; tick(); start5 = 1'b0;
        run_seq("s4r");
        check("s4r sig", 32'(sig5), 0);
        check("s4r pass", 32'(pass5), 1);

        // Start held high: back-to-back runs with a single DONE cycle between
        rst = 1'b1; tick(); rst = 1'b0;
        start5 = 1'b1; tick();
        run_seq("s5a");
        tick();
        check("s5 done_one_cycle", 32'(done5), 0);
        run_seq("s5b");
        repeat (8) tick();
        start5 = 1'b0;

        // 15-pattern buffer CUT: full LFSR period, signature 8
        golden15 = 4'h8; seen = '0;
        start15 = 1'b1; tick(); start15 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("s3 pat[%0d]", i), 32'(pat15), 32'(exp15[i]));
            check($sformatf("s3 norepeat[%0d]", i), 32'(seen[pat15]), 0);
            seen[pat15] = 1'b1;
            tick();
        end
        for (int w = 0; w < 4 && !done15; w++) tick();
        check("s3 done", 32'(done15), 1);
        check("s3 idx", 32'(idx15), 15);
        check("s3 sig", 32'(sig15), 32'h8);
        check("s3 pass", 32'(pass15), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
